// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_STALL_I = 3'd1,
        ST_STALL_D = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_HALTED  = 3'd4
    } pipe_state_e;

    localparam int   DRAIN_CYCLES_DEFAULT = 3;
    localparam int   DRAIN_CNT_W          = 8;
    localparam logic RST_ACTIVE           = 1'b0;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard comparator; shared with the forwarding logic.
module pipe_hazard_detect (
    input  logic [3:0] IFIDSrcReg1,
    input  logic [3:0] IFIDSrcReg2,
    input  logic       IFIDUsesSrc2,
    input  logic [3:0] IDEXRegWrite,
    input  logic       IDEXMemRd,
    output logic       LoadUse
);

    logic match1;
    logic match2;

    assign match1  = (IDEXRegWrite == IFIDSrcReg1);
    assign match2  = IFIDUsesSrc2 && (IDEXRegWrite == IFIDSrcReg2);
    // R0 is hardwired, so a load into it never creates a dependency
    assign LoadUse = IDEXMemRd && (IDEXRegWrite != 4'd0) && (match1 || match2);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush/halt-drain controller for the 5-stage pipeline.
// Optional perf counters (StallCycles, FlushCount) under `PIPE_CTRL_PERF_EN.
//
//   state    | meaning
//   RUN      | normal flow; hazards, branches and halt evaluated
//   STALL_I  | instruction memory busy, front end frozen
//   STALL_D  | data memory busy, whole pipe frozen (returns to RUN or DRAIN)
//   DRAIN    | halt moving through EX/MEM/WB, drain counter running
//   HALTED   | pipeline drained, everything frozen until reset
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] IFIDSrcReg1,
    input  logic [3:0] IFIDSrcReg2,
    input  logic       IFIDUsesSrc2,
    input  logic [3:0] IDEXRegWrite,
    input  logic       IDEXMemRd,
    input  logic       BranchTaken,
    input  logic       HltID,
    input  logic       IMemBusy,
    input  logic       DMemBusy,
    output logic       PCWriteEnable,
    output logic       IFIDWriteEnable,
    output logic       IDEXWriteEnable,
    output logic       EXMEMWriteEnable,
    output logic       MEMWBWriteEnable,
    output logic       IFIDNoop,
    output logic       IDEXNoop,
    output logic       EXMEMNoop,
    output logic       MEMWBNoop,
    output logic       Halted,
    output logic [2:0] State
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [15:0] StallCycles,
    output logic [15:0] FlushCount
`endif
);

    pipe_state_e            state_q, state_d, mode;
    logic                   from_drain_q, from_drain_d;
    logic [DRAIN_CNT_W-1:0] cnt_q, cnt_d;
    logic                   load_use;
    logic                   in_rst;
    logic                   pc_we, ifid_we, idex_we, exmem_we, memwb_we;
    logic                   ifid_noop, idex_noop, exmem_noop, memwb_noop;
    logic                   halted;

    pipe_hazard_detect u_hazard (
        .IFIDSrcReg1  (IFIDSrcReg1),
        .IFIDSrcReg2  (IFIDSrcReg2),
        .IFIDUsesSrc2 (IFIDUsesSrc2),
        .IDEXRegWrite (IDEXRegWrite),
        .IDEXMemRd    (IDEXMemRd),
        .LoadUse      (load_use)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            state_q      <= ST_RUN;
            from_drain_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            from_drain_q <= from_drain_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        from_drain_d = from_drain_q;
        cnt_d        = cnt_q;
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        idex_we      = 1'b1;
        exmem_we     = 1'b1;
        memwb_we     = 1'b1;
        ifid_noop    = 1'b0;
        idex_noop    = 1'b0;
        exmem_noop   = 1'b0;
        memwb_noop   = 1'b0;
        halted       = 1'b0;

        // A stall state whose cause has cleared behaves like the state it
        // came from, so a stall costs exactly as many cycles as the busy.
        mode = state_q;
        if (state_q == ST_STALL_I) mode = ST_RUN;
        if (state_q == ST_STALL_D) mode = from_drain_q ? ST_DRAIN : ST_RUN;

        case (mode)
            ST_HALTED: begin
                pc_we    = 1'b0;
                ifid_we  = 1'b0;
                idex_we  = 1'b0;
                exmem_we = 1'b0;
                memwb_we = 1'b0;
                halted   = 1'b1;
                state_d  = ST_HALTED;
            end
            ST_DRAIN: begin
                if (DMemBusy) begin
                    pc_we        = 1'b0;
                    ifid_we      = 1'b0;
                    idex_we      = 1'b0;
                    exmem_we     = 1'b0;
                    memwb_we     = 1'b0;
                    memwb_noop   = 1'b1;
                    state_d      = ST_STALL_D;
                    from_drain_d = 1'b1;
                end else begin
                    pc_we     = 1'b0;
                    ifid_noop = 1'b1;
                    idex_noop = 1'b1;
                    if (cnt_q <= DRAIN_CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_HALTED;
                    end else begin
                        cnt_d   = cnt_q - DRAIN_CNT_W'(1);
                        state_d = ST_DRAIN;
                    end
                end
            end
            default: begin
                if (DMemBusy) begin
                    pc_we        = 1'b0;
                    ifid_we      = 1'b0;
                    idex_we      = 1'b0;
                    exmem_we     = 1'b0;
                    memwb_we     = 1'b0;
                    memwb_noop   = 1'b1;
                    state_d      = ST_STALL_D;
                    from_drain_d = 1'b0;
                end else if (IMemBusy) begin
                    pc_we     = 1'b0;
                    ifid_we   = 1'b0;
                    idex_noop = 1'b1;
                    state_d   = ST_STALL_I;
                end else if (load_use) begin
                    pc_we     = 1'b0;
                    ifid_we   = 1'b0;
                    idex_noop = 1'b1;
                    state_d   = ST_RUN;
                end else if (BranchTaken) begin
                    ifid_noop = 1'b1;
                    state_d   = ST_RUN;
                end else if (HltID) begin
                    pc_we     = 1'b0;
                    ifid_noop = 1'b1;
                    cnt_d     = DRAIN_CNT_W'(DRAIN_CYCLES);
                    state_d   = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    // During reset every register loads a bubble
    assign in_rst           = (rst == RST_ACTIVE);
    assign PCWriteEnable    = in_rst | pc_we;
    assign IFIDWriteEnable  = in_rst | ifid_we;
    assign IDEXWriteEnable  = in_rst | idex_we;
    assign EXMEMWriteEnable = in_rst | exmem_we;
    assign MEMWBWriteEnable = in_rst | memwb_we;
    assign IFIDNoop         = in_rst | ifid_noop;
    assign IDEXNoop         = in_rst | idex_noop;
    assign EXMEMNoop        = in_rst | exmem_noop;
    assign MEMWBNoop        = in_rst | memwb_noop;
    assign Halted           = !in_rst && halted;
    assign State            = in_rst ? ST_RUN : state_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [15:0] stall_cnt_q, flush_cnt_q;
    logic        stall_cycle, flush;

    assign stall_cycle = !pc_we && (state_q == ST_RUN || state_q == ST_STALL_I ||
                                    state_q == ST_STALL_D);
    // An IF/ID flush with the PC still advancing only happens for a taken branch
    assign flush       = ifid_noop && pc_we;

    always_ff @(posedge clk) begin
        if (rst == RST_ACTIVE) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_cycle && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 16'd1;
            if (flush && flush_cnt_q != 16'hFFFF)       flush_cnt_q <= flush_cnt_q + 16'd1;
        end
    end

    assign StallCycles = stall_cnt_q;
    assign FlushCount  = flush_cnt_q;
`endif

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush controller for the 5-stage 16-bit pipeline. It drives the `WriteEnable` and `NoopIn` inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC write enable. It does this from load-use hazards, taken branches, instruction/data memory busy signals and halt. It sits beside the decode stage and owns all pipeline sequencing, including the halt drain.

## Interface
Parameters:
- `DRAIN_CYCLES`, 3: cycles after halt leaves ID until `Halted` (EX, MEM, WB).

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-low reset.
- `IFIDSrcReg1`, `IFIDSrcReg2`  input  4 each  source registers of the instruction in ID.
- `IFIDUsesSrc2`  input  1  instruction in ID reads `IFIDSrcReg2`.
- `IDEXRegWrite`  input  4  destination register of the instruction in EX.
- `IDEXMemRd`  input  1  instruction in EX is a load (`Mem_En & ~Mem_Wr`).
- `BranchTaken`  input  1  branch in ID resolved taken this cycle.
- `HltID`  input  1  halt decoded in ID.
- `IMemBusy`, `DMemBusy`  input  1 each  instruction/data memory not ready.
- `PCWriteEnable`  output  1  PC update enable.
- `IFIDWriteEnable`, `IDEXWriteEnable`, `EXMEMWriteEnable`, `MEMWBWriteEnable`  output  1 each  register write enables.
- `IFIDNoop`, `IDEXNoop`, `EXMEMNoop`, `MEMWBNoop`  output  1 each  bubble insert; the target register clears on the next edge.
- `Halted`  output  1  pipeline drained after halt.
- `State`  output  3  current FSM state, for debug.

## Operation
- FSM states: RUN=0, STALL_I=1, STALL_D=2, DRAIN=3, HALTED=4.
- Outputs are Mealy: registered state combined with current inputs, so a stall takes effect in the same cycle as its cause.
- Default in RUN: all WriteEnables=1, all Noops=0.
- Condition priority, highest first: `DMemBusy`, `IMemBusy`, load-use, `BranchTaken`, `HltID`.
- `DMemBusy`:
  - All WriteEnables=0, `MEMWBNoop`=1.
  - Next state STALL_D; stay while busy; return to RUN (or DRAIN if entered from DRAIN) when it clears.
- `IMemBusy`:
  - `PCWriteEnable`=0, `IFIDWriteEnable`=0, `IDEXNoop`=1; EX/MEM and MEM/WB advance.
  - Next state STALL_I while busy.
  - A branch in ID is held and re-evaluated after the stall.
- Load-use condition: `IDEXMemRd & (IDEXRegWrite!=0) & (IDEXRegWrite==IFIDSrcReg1 | (IFIDUsesSrc2 & IDEXRegWrite==IFIDSrcReg2))`.
  - Response: `PCWriteEnable`=0, `IFIDWriteEnable`=0, `IDEXNoop`=1 for exactly one cycle; state stays RUN.
- `BranchTaken` with no higher condition: `IFIDNoop`=1 (flush the wrong-path fetch); PC writes the target.
- `HltID` with no higher condition:
  - Halt advances into EX; `PCWriteEnable`=0, `IFIDNoop`=1.
  - Drain counter loads `DRAIN_CYCLES`; next state DRAIN.
- DRAIN:
  - `PCWriteEnable`=0, `IFIDNoop`=1, `IDEXNoop`=1.
  - Counter decrements each cycle with `DMemBusy`=0; at 0 go to HALTED.
  - `BranchTaken`, `HltID` and load-use are ignored.
- HALTED:
  - All WriteEnables=0, `Halted`=1; all inputs ignored until reset.

## Timing
- While `rst`=0:
  - All WriteEnables=1, all Noops=1, `Halted`=0, `State`=RUN.
  - On the edge, state becomes RUN and the drain counter 0.
- First edge with `rst`=1 starts normal operation; there are no pipeline bubbles beyond those flushed during reset.
- Reset asserted in any state, including mid-stall or HALTED, returns to RUN on the next edge.
- Stall latency is 0 cycles: the output changes combinationally in the cycle the cause is present.
- A load-use bubble costs exactly 1 cycle; a taken branch costs 1 cycle.
- `Halted` rises exactly `DRAIN_CYCLES` unstalled cycles after the cycle `HltID` is accepted.
- `DMemBusy` during DRAIN freezes the counter; it does not abort the drain.
- `IMemBusy` during DRAIN or HALTED is ignored.

## Configuration
- `PIPE_CTRL_PERF_EN` defined: two extra outputs, `StallCycles` (16) and `FlushCount` (16).
  - Both are saturating counters cleared by reset.
  - `StallCycles` increments in any cycle with `PCWriteEnable`=0 in RUN/STALL_I/STALL_D.
  - `FlushCount` increments per taken-branch flush.
- Undefined: ports and counters are absent; all other behaviour is identical.

## Structure
- Package `pipe_ctrl_pkg` holds:
  - state encodings (RUN..HALTED);
  - `DRAIN_CYCLES_DEFAULT`=3;
  - the `rst` active-level constant.
- Sub-module `pipe_hazard_detect`: combinational load-use comparator producing one `LoadUse` bit. It is reusable by the forwarding logic.

## Test plan
- Load at EX writing R3, ID reads R3 (`IDEXMemRd`=1) -> one cycle `PCWriteEnable`=0, `IFIDWriteEnable`=0, `IDEXNoop`=1, then RUN defaults; the same with `IDEXRegWrite`=0 -> no stall.
- `BranchTaken`=1 together with load-use -> the load-use response only; next cycle `BranchTaken`=1 alone -> `IFIDNoop`=1, `PCWriteEnable`=1.
- `DMemBusy` high 4 cycles -> `State`=2 for 4 cycles, all WriteEnables 0, `MEMWBNoop`=1; RUN on the 5th cycle.
- `IMemBusy` high 3 cycles with a taken branch in ID -> no flush during the stall; `IFIDNoop`=1 in the first cycle after busy drops.
- `HltID`=1 -> DRAIN 3 cycles (4 if `DMemBusy` pulses once during it), then `Halted`=1 and all WriteEnables 0; `rst`=0 -> `State`=0, `Halted`=0 after the edge.
- With `PIPE_CTRL_PERF_EN`, 2 load-use stalls + 1 branch -> `StallCycles`=2, `FlushCount`=1.
